// File: rtl/gcm_pkt_sequencer_if.sv
// gcm_pkt_sequencer_if: ingress stream plus gcm_aes core side of the packet sequencer.
// Latency: none (signal bundle only).
// Backpressure: s_ready is driven by the sequencer and gates s_valid; i_aes_done returns credits.
// Ports (signals): s_valid/s_ready/s_last/s_data/s_len ingress stream; o_aes_* core word bus;
//   i_aes_done completion pulse; o_credits/o_pkt_cnt/o_err status.
// Modports: master = ingress/core environment, slave = the sequencer.
interface gcm_pkt_sequencer_if #(
  parameter int DATA_W = 128,
  parameter int LEN_W  = 16,
  parameter int IV_W   = 96
);
  logic              s_valid;
  logic              s_ready;
  logic              s_last;
  logic [DATA_W-1:0] s_data;
  logic [LEN_W-1:0]  s_len;

  logic              o_aes_valid;
  logic              o_aes_new;
  logic              o_aes_last;
  logic [1:0]        o_aes_phase;
  logic [DATA_W-1:0] o_aes_data;
  logic [127:0]      o_aes_pt_size;
  logic [IV_W-1:0]   o_aes_iv;
  logic              i_aes_done;

  logic [3:0]        o_credits;
  logic [31:0]       o_pkt_cnt;
  logic [1:0]        o_err;

  modport master (
    output s_valid, s_last, s_data, s_len, i_aes_done,
    input  s_ready, o_aes_valid, o_aes_new, o_aes_last, o_aes_phase, o_aes_data,
           o_aes_pt_size, o_aes_iv, o_credits, o_pkt_cnt, o_err
  );

  modport slave (
    input  s_valid, s_last, s_data, s_len, i_aes_done,
    output s_ready, o_aes_valid, o_aes_new, o_aes_last, o_aes_phase, o_aes_data,
           o_aes_pt_size, o_aes_iv, o_credits, o_pkt_cnt, o_err
  );
endinterface

// File: rtl/gcm_pkt_sequencer.sv
// gcm_pkt_sequencer: front-end controller for gcm_aes; tags words with new/last/phase,
//   computes plaintext bit size and IV per packet, limits packets in flight with credits.
// Latency: 1 cycle from accepted input word to o_aes_* output.
// Backpressure: s_ready drops only between packets when no credit is left; mid-packet always ready.
// Ports: clk, reset (sync, active-high); bus (slave modport of gcm_pkt_sequencer_if) carrying
//   the ingress stream, the core word bus, i_aes_done credit return and status outputs.
// Optional feature: define GCM_SEQ_IV_INC_EN for an incrementing per-packet IV; otherwise
//   o_aes_iv is tied to zero and no IV logic exists.
module gcm_pkt_sequencer #(
  parameter int DATA_W       = 128,
  parameter int LEN_W        = 16,
  parameter int HDR_BYTES    = 14,
  parameter int MAX_INFLIGHT = 4,
  parameter int IV_W         = 96
) (
  input logic               clk,
  input logic               reset,
  gcm_pkt_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SECOND = 2'd1,
    ST_INNER  = 2'd2
  } state_e;

  localparam logic [3:0]       MAX_CRED = 4'(MAX_INFLIGHT);
  localparam logic [LEN_W-1:0] HDR_LEN  = LEN_W'(HDR_BYTES);

  state_e            state_q, state_d;
  logic              aes_valid_q, aes_valid_d;
  logic              aes_new_q, aes_new_d;
  logic              aes_last_q, aes_last_d;
  logic [1:0]        aes_phase_q, aes_phase_d;
  logic [DATA_W-1:0] aes_data_q, aes_data_d;
  logic [127:0]      pt_size_q, pt_size_d;
  logic [3:0]        credits_q, credits_d;
  logic [31:0]       pkt_cnt_q, pkt_cnt_d;
  logic [1:0]        err_q, err_d;

  logic              s_ready;
  logic              accept;
  logic              first_acc;
  logic              stray_done;
  logic              credit_ret;
  logic [1:0]        phase_w;
  logic [LEN_W-1:0]  net_len;

  // Credits gate only the start of a packet; once inside, the packet always completes.
  assign s_ready    = (state_q != ST_IDLE) | (credits_q != 4'd0);
  assign accept     = bus.s_valid & s_ready;
  assign first_acc  = accept & (state_q == ST_IDLE);
  // A done pulse with every credit already home has no packet to retire.
  assign stray_done = bus.i_aes_done & (credits_q == MAX_CRED);
  assign credit_ret = bus.i_aes_done & ~stray_done;
  assign net_len    = bus.s_len - HDR_LEN;

  always_comb begin
    state_d     = state_q;
    phase_w     = 2'd0;
    aes_valid_d = accept;
    aes_new_d   = first_acc;
    aes_last_d  = accept & bus.s_last;
    aes_phase_d = 2'd0;
    aes_data_d  = aes_data_q;
    pt_size_d   = pt_size_q;
    credits_d   = credits_q;
    pkt_cnt_d   = pkt_cnt_q;
    err_d       = err_q;

    case (state_q)
      ST_IDLE: begin
        phase_w = 2'd0;
        if (accept && !bus.s_last) state_d = ST_SECOND;
      end
      ST_SECOND: begin
        phase_w = 2'd1;
        if (accept) state_d = bus.s_last ? ST_IDLE : ST_INNER;
      end
      ST_INNER: begin
        phase_w = 2'd2;
        if (accept && bus.s_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (accept) begin
      aes_phase_d = phase_w;
      aes_data_d  = bus.s_data;
    end

    // Length is only meaningful on the first word; later words leave size untouched.
    if (first_acc) begin
      pkt_cnt_d = pkt_cnt_q + 32'd1;
      if (bus.s_len < HDR_LEN) begin
        pt_size_d = 128'd0;
        err_d[0]  = 1'b1;
      end else begin
        pt_size_d = {{(128-LEN_W){1'b0}}, net_len} << 3;
      end
    end

    if (stray_done) err_d[1] = 1'b1;

    // Simultaneous start and return cancel out.
    if (first_acc && !credit_ret) begin
      credits_d = credits_q - 4'd1;
    end else if (credit_ret && !first_acc) begin
      credits_d = credits_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      aes_valid_q <= 1'b0;
      aes_new_q   <= 1'b0;
      aes_last_q  <= 1'b0;
      aes_phase_q <= 2'd0;
      aes_data_q  <= '0;
      pt_size_q   <= '0;
      credits_q   <= MAX_CRED;
      pkt_cnt_q   <= 32'd0;
      err_q       <= 2'b00;
    end else begin
      state_q     <= state_d;
      aes_valid_q <= aes_valid_d;
      aes_new_q   <= aes_new_d;
      aes_last_q  <= aes_last_d;
      aes_phase_q <= aes_phase_d;
      aes_data_q  <= aes_data_d;
      pt_size_q   <= pt_size_d;
      credits_q   <= credits_d;
      pkt_cnt_q   <= pkt_cnt_d;
      err_q       <= err_d;
    end
  end

`ifdef GCM_SEQ_IV_INC_EN
  logic [IV_W-1:0] iv_q, iv_d;
  logic [IV_W-1:0] aes_iv_q, aes_iv_d;

  // The packet gets the counter value before it is bumped; all-ones wraps to zero.
  always_comb begin
    iv_d     = iv_q;
    aes_iv_d = aes_iv_q;
    if (first_acc) begin
      aes_iv_d = iv_q;
      iv_d     = iv_q + {{(IV_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      iv_q     <= '0;
      aes_iv_q <= '0;
    end else begin
      iv_q     <= iv_d;
      aes_iv_q <= aes_iv_d;
    end
  end

  assign bus.o_aes_iv = aes_iv_q;
`else
  assign bus.o_aes_iv = {IV_W{1'b0}};
`endif

  assign bus.s_ready       = s_ready;
  assign bus.o_aes_valid   = aes_valid_q;
  assign bus.o_aes_new     = aes_new_q;
  assign bus.o_aes_last    = aes_last_q;
  assign bus.o_aes_phase   = aes_phase_q;
  assign bus.o_aes_data    = aes_data_q;
  assign bus.o_aes_pt_size = pt_size_q;
  assign bus.o_credits     = credits_q;
  assign bus.o_pkt_cnt     = pkt_cnt_q;
  assign bus.o_err         = err_q;

endmodule
